regfile_write_arbiter: RTL

Shares the register file's single write port between N_REQ independent requesters (e.g. demodulator, control FSM, host config) using round-robin arbitration with a valid/ready handshake. The block registers the winning request and drives the register file's write_en/write_addr/write_data, which commit on the following falling clock edge. It also filters writes to write-protected registers and counts the writes it drops.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_write_arbiter_rr_picker.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, limits and lock-state encodings for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int ADDR_WIDTH    = 5;
  localparam int DATA_WIDTH    = 16;
  localparam int REG_DEPTH     = 32;
  localparam int ARB_N_REQ_MAX = 4;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: the first valid requester after ptr wins.
module regfile_write_arbiter_rr_picker
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       idx
);

  logic       found;
  logic [1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_idx = 2'((int'(ptr) + off) % N_REQ);
      if (!found && valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
        grant = N_REQ'(1) << cand_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port with write protection and a drop counter.
// Define REGFILE_ARB_LOCK_EN to let a requester lock the port for a burst.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int          N_REQ        = 3,
  parameter logic [31:0] PROTECT_MASK = 32'h0000_0001,
  parameter int          CNT_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rf_write_en,
  output logic [ADDR_WIDTH-1:0]       rf_write_addr,
  output logic [DATA_WIDTH-1:0]       rf_write_data,
  output logic [1:0]                  last_gnt,
  output logic                        err_pulse,
  output logic [CNT_WIDTH-1:0]        drop_cnt
);

  logic [1:0]            rr_ptr;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      grant;
  logic [1:0]            gnt_idx;
  logic                  transfer;
  logic                  blocked;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  regfile_write_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = arb_en ? grant : '0;
  assign transfer  = |req_ready;
  assign win_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign blocked   = PROTECT_MASK[win_addr];

`ifdef REGFILE_ARB_LOCK_EN
  arb_state_t state, next_state;
  logic [1:0] lock_owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_OPEN;
      lock_owner <= '0;
    end else begin
      state <= next_state;
      if (state == ARB_OPEN && next_state == ARB_LOCKED)
        lock_owner <= gnt_idx;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_OPEN:   if (transfer && req_lock[gnt_idx]) next_state = ARB_LOCKED;
      ARB_LOCKED: if (!arb_en || (transfer && !req_lock[gnt_idx])) next_state = ARB_OPEN;
      default:    next_state = ARB_OPEN;
    endcase
  end

  // While locked, the owner is the only candidate even when it is idle.
  always_comb begin
    eligible = req_valid;
    if (state == ARB_LOCKED)
      eligible = req_valid & (N_REQ'(1) << lock_owner);
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign eligible    = req_valid;
`endif

  // Protected writes are still accepted so the requester moves on; they only bump the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= 2'(N_REQ-1);
      last_gnt      <= '0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      err_pulse     <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      rf_write_en <= transfer && !blocked;
      err_pulse   <= transfer && blocked;
      if (transfer) begin
        rr_ptr   <= gnt_idx;
        last_gnt <= gnt_idx;
      end
      if (transfer && !blocked) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
      if (transfer && blocked && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
